alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Execution-stage ALU that consumes the 3-bit operation code produced by the ALU control decoder and performs the operation on two 32-bit operands. AND, OR, ADD and SUB complete in one cycle. MUL uses a shift-add iterative multiplier that takes 32 cycles. A valid/ready handshake lets the pipeline control logic stall issue while a multiply is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width. Multiply iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, synchronous, active-high
- valid_i  input  1  operation request
- ready_o  output  1  block can accept a request this cycle
- ALUCtrl_i  input  3  operation code: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL; 101–111 reserved
- data1_i  input  WIDTH  operand A
- data2_i  input  WIDTH  operand B
- data_o  output  WIDTH  registered result
- zero_o  output  1  high when data_o == 0 (combinational from data_o)
- valid_o  output  1  one-cycle pulse when data_o carries a new result

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: multiply iterating.
  - DONE: result presented.
- ready_o is 1 in IDLE and DONE and 0 in MUL.
- Accept occurs on a rising edge where valid_i && ready_o. ALUCtrl_i, data1_i and data2_i are captured at accept. Later changes to the inputs have no effect on the accepted operation.
- Single-cycle ops (000/001/010/011) and reserved codes:
  - data_o is loaded at the accept edge and the state goes to DONE.
  - AND/OR are bitwise. ADD is A+B and SUB is A−B, both mod 2^WIDTH, with no overflow or carry output.
  - Reserved codes (101–111) produce data_o = 0.
- MUL:
  - At accept, load mcand = A, mplier = B, acc = 0 and count = 0, then go to MUL.
  - Each MUL cycle: if mplier[0], acc += mcand (mod 2^WIDTH). Then mcand <<= 1, mplier >>= 1 and count++.
  - On the edge that completes iteration WIDTH, data_o ← final acc and the state goes to DONE.
  - The result is the low WIDTH bits of the unsigned product. The low bits are identical for two's-complement operands.
  - There is no early termination; a multiply always takes WIDTH iterations.
- DONE:
  - valid_o = 1 for this single cycle.
  - If valid_i is high, the next request is accepted at the same edge.
  - Otherwise the state returns to IDLE.
- data_o holds its last value until the next result is written. It is never cleared except by reset.
- valid_i while ready_o = 0 is ignored and is not queued. The requester must hold the request until it sees ready_o.

## Timing
- Reset (rst_i high at an edge), effective that edge regardless of state:
  - state = IDLE, data_o = 0, zero_o = 1, valid_o = 0, ready_o = 1.
  - An in-flight multiply is discarded and produces no valid_o.
- Latency is counted from the accept edge E0:
  - Single-cycle op: valid_o is high in the cycle after E0.
  - MUL: the iterations run on edges E1..E32, and valid_o is high in the cycle after E32 (33 cycles after accept).
- Throughput:
  - Back-to-back single-cycle ops accepted in DONE: one result every cycle after the first.
  - MUL blocks new requests for WIDTH cycles.
- Reset asserted in the same cycle as valid_i: reset wins and nothing is accepted.
- zero_o tracks data_o with no extra register stage.

## Test plan
- Reset, then ADD with A = 0x00000005, B = 0x00000007 → valid_o high one cycle after accept, data_o = 0x0000000C, zero_o = 0.
- SUB with A = 3, B = 3 → data_o = 0, zero_o = 1. SUB with A = 0, B = 1 → data_o = 0xFFFFFFFF.
- MUL with A = 7, B = 6 → ready_o low for 32 cycles, valid_o exactly 33 cycles after accept, data_o = 42. MUL with A = 0x00010000, B = 0x00010000 → data_o = 0 (wrap). MUL with A = 0xFFFFFFFF (−1), B = 5 → data_o = 0xFFFFFFFB.
- Back-to-back single-cycle ops:
  - Stimulus: valid_i held high with AND (0xF0F0F0F0 & 0xFF00FF00), then OR (0x0F & 0xF0), then reserved code 101.
  - Required response: three consecutive valid_o pulses with data_o = 0xF000F000, 0x000000FF, 0x00000000.
- Ignored requests while busy:
  - Stimulus: start a MUL; during the MUL, drive valid_i with ADD 1+1 and change data1_i/data2_i.
  - Required response: the ADD is not accepted, the MUL result is unaffected, and exactly one valid_o pulse occurs.
- Reset mid-operation: assert rst_i at iteration 10 of a MUL → next cycle data_o = 0, zero_o = 1, ready_o = 1, and no valid_o pulse follows.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Request/result bus of the multicycle ALU.
//   master (pipeline side): drives valid_i, ALUCtrl_i, data1_i, data2_i and
//                           observes ready_o, data_o, zero_o, valid_o
//   slave  (ALU side)     : the mirror image
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             valid_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  ready_o, data_o, zero_o, valid_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output ready_o, data_o, zero_o, valid_o
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: AND/OR/ADD/SUB in one cycle, MUL via a WIDTH-iteration
// shift-add multiplier, valid/ready handshake to stall issue during MUL.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of alu_multicycle_if (request in, registered result out);
//           the interface WIDTH must match this module's WIDTH
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_multicycle_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] acc_step;

    assign ready       = (state_q != S_MUL);
    assign accept      = bus.valid_i && ready;
    assign bus.ready_o = ready;
    assign bus.data_o  = data_q;
    assign bus.zero_o  = (data_q == '0);
    assign bus.valid_o = (state_q == S_DONE);

    // Single-cycle result; reserved codes (and MUL, unused here) give zero.
    always_comb begin
        alu_result = '0;
        case (bus.ALUCtrl_i)
            OP_AND:  alu_result = bus.data1_i & bus.data2_i;
            OP_OR:   alu_result = bus.data1_i | bus.data2_i;
            OP_ADD:  alu_result = bus.data1_i + bus.data2_i;
            OP_SUB:  alu_result = bus.data1_i - bus.data2_i;
            default: alu_result = '0;
        endcase
    end

    // One shift-add step: accumulate the multiplicand if the current multiplier bit is set.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (bus.ALUCtrl_i == OP_MUL) begin
                        mcand_d  = bus.data1_i;
                        mplier_d = bus.data2_i;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_MUL;
                    end else begin
                        data_d  = alu_result;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // Final iteration writes the result straight from the adder.
                if (count_q == LAST_ITER) begin
                    data_d  = acc_step;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_multicycle;
    localparam int unsigned WIDTH = 32;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_fail;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation code.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return prod[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, wait for its result and check value, latency, stall and pulse width.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit busy_noise);
        int          waited;
        int          lat;
        int          stall;
        logic [31:0] exp;
        exp    = model(op, a, b);
        waited = 0;
        while (!bus.ready_o && waited < 64) begin
            tick();
            waited++;
        end
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        tick();
        bus.valid_i = 1'b0;
        bus.data1_i = $urandom;
        bus.data2_i = $urandom;
        lat   = 1;
        stall = 0;
        while (!bus.valid_o && lat < 100) begin
            if (!bus.ready_o) stall++;
            if (busy_noise && !bus.ready_o) begin
                bus.valid_i   = 1'b1;
                bus.ALUCtrl_i = 3'd2;
                bus.data1_i   = (lat % 2 == 0) ? 32'd1 : $urandom;
                bus.data2_i   = (lat % 2 == 0) ? 32'd1 : $urandom;
            end else begin
                bus.valid_i = 1'b0;
            end
            tick();
            lat++;
        end
        bus.valid_i = 1'b0;
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_latency"}, 32'(lat), (op == 3'd4) ? 32'd33 : 32'd1);
        check({tag, "_stall"}, 32'(stall), (op == 3'd4) ? 32'd32 : 32'd0);
        check({tag, "_data"}, bus.data_o, exp);
        check({tag, "_zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
        tick();
        check({tag, "_pulse"}, 32'(bus.valid_o), 32'd0);
        check({tag, "_hold"}, bus.data_o, exp);
    endtask

    initial begin
        int          pulses;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks      = 0;
        n_fail        = 0;
        rst_i         = 1'b1;
        bus.valid_i   = 1'b0;
        bus.ALUCtrl_i = 3'd0;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_data", bus.data_o, 32'd0);
        check("rst_zero", 32'(bus.zero_o), 32'd1);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);

        run_op("add_5_7", 3'd2, 32'h5, 32'h7, 1'b0);
        run_op("sub_3_3", 3'd3, 32'd3, 32'd3, 1'b0);
        run_op("sub_0_1", 3'd3, 32'd0, 32'd1, 1'b0);
        run_op("mul_7_6", 3'd4, 32'd7, 32'd6, 1'b0);
        run_op("mul_wrap", 3'd4, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op("mul_neg", 3'd4, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_op("mul_noise", 3'd4, 32'h0000_1234, 32'h0000_0101, 1'b1);
        check("noise_idle", 32'(bus.valid_o), 32'd0);

        // Back-to-back single-cycle ops with valid_i held high.
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 3'd0;
        bus.data1_i   = 32'hF0F0_F0F0;
        bus.data2_i   = 32'hFF00_FF00;
        tick();
        check("b2b_and_valid", 32'(bus.valid_o), 32'd1);
        check("b2b_and_data", bus.data_o, 32'hF000_F000);
        bus.ALUCtrl_i = 3'd1;
        bus.data1_i   = 32'h0F;
        bus.data2_i   = 32'hF0;
        tick();
        check("b2b_or_valid", 32'(bus.valid_o), 32'd1);
        check("b2b_or_data", bus.data_o, 32'h0000_00FF);
        bus.ALUCtrl_i = 3'b101;
        bus.data1_i   = 32'hDEAD_BEEF;
        bus.data2_i   = 32'h1234_5678;
        tick();
        bus.valid_i = 1'b0;
        check("b2b_rsv_valid", 32'(bus.valid_o), 32'd1);
        check("b2b_rsv_data", bus.data_o, 32'd0);
        check("b2b_rsv_zero", 32'(bus.zero_o), 32'd1);
        tick();
        check("b2b_end", 32'(bus.valid_o), 32'd0);

        // Reset during iteration 10 of a multiply.
        run_op("pre_rst_add", 3'd2, 32'h100, 32'h23, 1'b0);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 3'd4;
        bus.data1_i   = 32'd9;
        bus.data2_i   = 32'd11;
        tick();
        bus.valid_i = 1'b0;
        repeat (9) tick();
        check("mid_busy", 32'(bus.ready_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_data", bus.data_o, 32'd0);
        check("mid_rst_zero", 32'(bus.zero_o), 32'd1);
        check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o) pulses++;
            tick();
        end
        check("mid_rst_pulses", 32'(pulses), 32'd0);

        // Reset wins over a simultaneous request.
        run_op("pre_rst2_or", 3'd1, 32'h8000_0000, 32'h1, 1'b0);
        rst_i         = 1'b1;
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 3'd2;
        bus.data1_i   = 32'd5;
        bus.data2_i   = 32'd7;
        tick();
        rst_i       = 1'b0;
        bus.valid_i = 1'b0;
        check("rst_req_valid", 32'(bus.valid_o), 32'd0);
        check("rst_req_data", bus.data_o, 32'd0);
        tick();
        check("rst_req_valid2", 32'(bus.valid_o), 32'd0);
        check("rst_req_data2", bus.data_o, 32'd0);

        // Randomized operations, some with edge-value operands.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb  = (i % 7 == 0) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = ra;
            run_op("rand", rop, ra, rb, i[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog keeps the run bounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
